// File: rtl/systolic_feed_sequencer.sv
// Read sequencer and host write arbiter for the input RAM banks of the systolic array.
// Runs issue diagonally skewed reads (bank i lags bank 0 by i cycles); idle time serves host writes.
module systolic_feed_sequencer #(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 4,
  parameter int DEPTH     = 16,
  parameter int DATA_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ADDR_W:0]             len,
  output logic                        busy,
  output logic                        done,
  output logic [NUM_BANKS-1:0]        bank_en,
  output logic [NUM_BANKS-1:0]        bank_we,
  output logic [NUM_BANKS*ADDR_W-1:0] bank_addr,
  output logic [DATA_W-1:0]           bank_di,
  output logic [NUM_BANKS-1:0]        lane_valid,
  input  logic                        hw_req,
  input  logic [1:0]                  hw_bank,
  input  logic [ADDR_W-1:0]           hw_addr,
  input  logic [DATA_W-1:0]           hw_data,
  output logic                        hw_ack,
  output logic [1:0]                  dbg_state
);

  localparam int CW = ADDR_W + 2;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [1:0]                  state_q, state_d;
  logic [CW-1:0]               t_q, t_d;
  logic [ADDR_W:0]             len_q, len_d;
  logic [ADDR_W:0]             len_c;
  logic [CW-1:0]               t_last;
  logic                        wr_go;

  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic [NUM_BANKS-1:0]        en_q, en_d;
  logic [NUM_BANKS-1:0]        we_q, we_d;
  logic [NUM_BANKS*ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]           di_q, di_d;
  logic                        ack_q, ack_d;
  logic [NUM_BANKS-1:0]        lv_q;

  assign len_c  = (len > DEPTH_L) ? DEPTH_L : len;
  assign t_last = {1'b0, len_q} + CW'(NUM_BANKS - 2);
  // Host handshake: hw_req is a level request; hw_ack marks the cycle the write reaches the bank.
  // A request is only taken on an IDLE edge with no competing start, otherwise it simply waits.
  assign wr_go  = (state_q == S_IDLE) && !start && hw_req;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    len_d   = len_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_c != '0) begin
            state_d = S_RUN;
            t_d     = '0;
            len_d   = len_c;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (t_q == t_last) state_d = S_DRAIN;
        else               t_d     = t_q + 1'b1;
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        t_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the next-state values.
  always_comb begin
    en_d   = '0;
    we_d   = '0;
    addr_d = '0;
    di_d   = '0;
    ack_d  = 1'b0;
    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    for (int i = 0; i < NUM_BANKS; i++) begin
      if ((state_d == S_RUN) && (t_d >= CW'(i)) && (t_d < CW'(i) + {1'b0, len_d})) begin
        en_d[i]                    = 1'b1;
        addr_d[i*ADDR_W +: ADDR_W] = ADDR_W'(t_d - CW'(i));
      end
    end
    if (wr_go) begin
      en_d[hw_bank]                    = 1'b1;
      we_d[hw_bank]                    = 1'b1;
      addr_d[hw_bank*ADDR_W +: ADDR_W] = hw_addr;
      di_d                             = hw_data;
      ack_d                            = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= '0;
      we_q    <= '0;
      addr_q  <= '0;
      di_q    <= '0;
      ack_q   <= 1'b0;
      lv_q    <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      di_q    <= di_d;
      ack_q   <= ack_d;
      lv_q    <= en_q & ~we_q;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign bank_en    = en_q;
  assign bank_we    = we_q;
  assign bank_addr  = addr_q;
  assign bank_di    = di_q;
  assign lane_valid = lv_q;
  assign hw_ack     = ack_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_systolic_feed_sequencer.sv
// Directed bench for systolic_feed_sequencer: skewed read timing, host writes, contention,
// mid-run reset and len boundaries, with a behavioural model of the four RAM banks.
module tb_systolic_feed_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  len;
  logic        busy;
  logic        done;
  logic [3:0]  bank_en;
  logic [3:0]  bank_we;
  logic [15:0] bank_addr;
  logic [15:0] bank_di;
  logic [3:0]  lane_valid;
  logic        hw_req;
  logic [1:0]  hw_bank;
  logic [3:0]  hw_addr;
  logic [15:0] hw_data;
  logic        hw_ack;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_fail;

  logic [15:0] ram     [4][16];
  logic [15:0] rdo     [4];
  logic [15:0] exp_mem [4][16];
  logic [15:0] exp_q[$];

  systolic_feed_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .bank_en    (bank_en),
    .bank_we    (bank_we),
    .bank_addr  (bank_addr),
    .bank_di    (bank_di),
    .lane_valid (lane_valid),
    .hw_req     (hw_req),
    .hw_bank    (hw_bank),
    .hw_addr    (hw_addr),
    .hw_data    (hw_data),
    .hw_ack     (hw_ack),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // behavioural RAM banks, one-cycle read latency
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bank_en[b]) begin
        if (bank_we[b]) ram[b][bank_addr[b*4 +: 4]] <= bank_di;
        else            rdo[b] <= ram[b][bank_addr[b*4 +: 4]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " busy"},  busy, 0);
    check({tag, " done"},  done, 0);
    check({tag, " en"},    bank_en, 0);
    check({tag, " we"},    bank_we, 0);
    check({tag, " addr"},  bank_addr, 0);
    check({tag, " di"},    bank_di, 0);
    check({tag, " lv"},    lane_valid, 0);
    check({tag, " ack"},   hw_ack, 0);
    check({tag, " state"}, dbg_state, 0);
  endtask

  task automatic hw_write(input int b, input int a, input logic [15:0] d);
    hw_req  = 1'b1;
    hw_bank = 2'(b);
    hw_addr = 4'(a);
    hw_data = d;
    step();
    check($sformatf("wr b%0d a%0d ack", b, a), hw_ack, 1);
    check($sformatf("wr b%0d a%0d we", b, a), bank_we, 32'(1) << b);
    check($sformatf("wr b%0d a%0d en", b, a), bank_en, 32'(1) << b);
    check($sformatf("wr b%0d a%0d addr", b, a), bank_addr, 32'(a) << (4*b));
    check($sformatf("wr b%0d a%0d di", b, a), bank_di, d);
    check($sformatf("wr b%0d a%0d lv", b, a), lane_valid, 0);
    exp_mem[b][a] = d;
  endtask

  // Drives one run from IDLE and checks every cycle from C1 through the IDLE cycle after done.
  task automatic do_run(input int len_in, input bit chk_data, input bit poke_start, input bit hold_req);
    int L;
    int total;
    logic        e_busy, e_done;
    logic [3:0]  e_en, e_lv;
    logic [15:0] e_addr;
    L     = (len_in > 16) ? 16 : len_in;
    total = (L == 0) ? 2 : L + 6;
    start  = 1'b1;
    len    = 5'(len_in);
    hw_req = hold_req;
    step();
    for (int k = 1; k <= total; k++) begin
      start  = poke_start && (k < total);
      e_busy = (L > 0) && (k <= L + 4);
      e_done = (L == 0) ? (k == 1) : (k == L + 5);
      e_en   = '0;
      e_lv   = '0;
      e_addr = '0;
      for (int i = 0; i < 4; i++) begin
        if (L > 0 && k >= 1 + i && k <= i + L) begin
          e_en[i]         = 1'b1;
          e_addr[i*4 +: 4] = 4'(k - 1 - i);
        end
        if (L > 0 && k >= 2 + i && k <= 1 + i + L) e_lv[i] = 1'b1;
      end
      check($sformatf("len%0d c%0d busy", len_in, k), busy, e_busy);
      check($sformatf("len%0d c%0d done", len_in, k), done, e_done);
      check($sformatf("len%0d c%0d en", len_in, k), bank_en, e_en);
      check($sformatf("len%0d c%0d addr", len_in, k), bank_addr, e_addr);
      check($sformatf("len%0d c%0d lv", len_in, k), lane_valid, e_lv);
      check($sformatf("len%0d c%0d we", len_in, k), bank_we, 0);
      check($sformatf("len%0d c%0d di", len_in, k), bank_di, 0);
      check($sformatf("len%0d c%0d ack", len_in, k), hw_ack, 0);
      if (chk_data) begin
        for (int i = 0; i < 4; i++) begin
          if (e_lv[i]) check($sformatf("len%0d c%0d data%0d", len_in, k, i), rdo[i], exp_mem[i][k-2-i]);
        end
      end
      if (k == total) check($sformatf("len%0d idle state", len_in), dbg_state, 0);
      if (k < total) step();
    end
    start = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int b = 0; b < 4; b++) begin
      for (int a = 0; a < 16; a++) begin
        ram[b][a]     = '0;
        exp_mem[b][a] = '0;
      end
      rdo[b] = '0;
    end
    rst_n   = 1'b0;
    start   = 1'b0;
    len     = '0;
    hw_req  = 1'b0;
    hw_bank = '0;
    hw_addr = '0;
    hw_data = '0;

    // power-on reset
    step();
    step();
    check_quiet("por");
    rst_n = 1'b1;
    step();

    // distinct operands in banks 0..3, addresses 0..5
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 6; a++)
        hw_write(b, a, 16'(16'h1000 * (b + 1) + a));
    hw_req = 1'b0;
    step();
    check("load end ack", hw_ack, 0);

    // skewed read, len 6
    do_run(6, 1'b1, 1'b0, 1'b0);

    // reset in the middle of a len 6 run at t=3
    start = 1'b1;
    len   = 5'd6;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("mid C4 busy", busy, 1);
    check("mid C4 en", bank_en, 4'b1111);
    rst_n = 1'b0;
    step();
    check_quiet("rst1");
    step();
    check_quiet("rst2");
    rst_n = 1'b1;
    step();
    check_quiet("post rst1");
    step();
    check_quiet("post rst2");
    do_run(6, 1'b1, 1'b0, 1'b0);

    // host load stream into bank 2, then full-depth readback
    for (int a = 0; a < 16; a++) exp_q.push_back(16'(a + 100));
    hw_req = 1'b1;
    for (int a = 0; a < 16; a++) begin
      logic [15:0] exp_di;
      hw_bank = 2'd2;
      hw_addr = 4'(a);
      hw_data = 16'(a + 100);
      step();
      exp_di = exp_q.pop_front();
      check($sformatf("stream a%0d ack", a), hw_ack, 1);
      check($sformatf("stream a%0d we", a), bank_we, 4'b0100);
      check($sformatf("stream a%0d en", a), bank_en, 4'b0100);
      check($sformatf("stream a%0d addr", a), bank_addr, 32'(a) << 8);
      check($sformatf("stream a%0d di", a), bank_di, exp_di);
      check($sformatf("stream a%0d lv", a), lane_valid, 0);
      exp_mem[2][a] = exp_di;
    end
    hw_req = 1'b0;
    step();
    check("stream end ack", hw_ack, 0);
    check("stream end lv", lane_valid, 0);
    check("stream queue empty", exp_q.size(), 0);
    do_run(16, 1'b1, 1'b0, 1'b0);

    // len above depth is clamped
    do_run(20, 1'b1, 1'b0, 1'b0);

    // len 0: done only
    do_run(0, 1'b0, 1'b0, 1'b0);

    // host request held across a len 4 run, raised together with start
    hw_bank = 2'd1;
    hw_addr = 4'd7;
    hw_data = 16'hBEEF;
    do_run(4, 1'b1, 1'b0, 1'b1);
    step();
    check("cont ack", hw_ack, 1);
    check("cont we", bank_we, 4'b0010);
    check("cont addr", bank_addr, 16'h0070);
    check("cont di", bank_di, 16'hBEEF);
    exp_mem[1][7] = 16'hBEEF;
    hw_req = 1'b0;
    step();
    check("cont ack drop", hw_ack, 0);
    check("cont we drop", bank_we, 0);

    // start held through RUN/DRAIN/DONE has no effect
    do_run(6, 1'b1, 1'b1, 1'b0);
    do_run(16, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
